// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-12 counter and its testbench.
//
// Contents:
//   COUNT_WIDTH        width of the count / load value (4 bits)
//   COUNT_MAX          largest legal count value (11)
//   count_t            logic vector type sized to hold one count value
//   no_of_transaction  number of random transactions the bench issues
package counter_pkg;

    localparam int COUNT_WIDTH = 4;
    localparam int COUNT_MAX   = 11;

    typedef logic [COUNT_WIDTH-1:0] count_t;

    localparam int unsigned no_of_transaction = 100;

endpackage : counter_pkg

// File: rtl/mod12_counter.sv
// Synchronous loadable up/down counter, modulo MODULUS (default 12).
//
// Ports:
//   clock     in   1      system clock, all state changes on the rising edge
//   reset     in   1      synchronous active-high reset, clears the count
//   load      in   1      load data_in on the next edge (out-of-range -> 0)
//   mode      in   1      count direction, 1 = up, 0 = down
//   data_in   in   WIDTH  parallel load value
//   data_out  out  WIDTH  registered count value, always in 0..MODULUS-1
//
// Edge priority: reset, then load, then counting in the direction of mode.
// The counter steps on every edge where neither reset nor load is high.
// MODULUS must not exceed 2**WIDTH.
module mod12_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = COUNT_WIDTH,
    parameter int MODULUS = COUNT_MAX + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // One count step with wrap-around in both directions.
    function automatic logic [WIDTH-1:0] wrap_step(
        input logic [WIDTH-1:0] value,
        input logic             up
    );
        logic [WIDTH-1:0] result;
        if (up) begin
            result = (value == MAX_VAL) ? '0 : value + ONE;
        end else begin
            result = (value == '0) ? MAX_VAL : value - ONE;
        end
        return result;
    endfunction

    // Loads above the top of the range are coerced to 0 so the register
    // can never hold an illegal count.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = (data_in <= MAX_VAL) ? data_in : '0;
        end else begin
            count_d = wrap_step(count_q, mode);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign data_out = count_q;

endmodule : mod12_counter

// File: tb/tb_mod12_counter.sv
// Self-checking bench for mod12_counter.
// Stimulus is driven on the falling edge; for every transaction the expected
// data_out is pushed into a scoreboard queue, and a separate monitor pops and
// compares just after each rising edge.
module tb_mod12_counter;
    import counter_pkg::*;

    logic   clock = 1'b0;
    logic   reset;
    logic   load;
    logic   mode;
    count_t data_in;
    count_t data_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int    exp;
        string name;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: plain integer count in 0..11.
    int model_cnt = 0;

    always #5 clock = ~clock;

    mod12_counter dut (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .mode     (mode),
        .data_in  (data_in),
        .data_out (data_out)
    );

    // Issue one transaction for the next rising edge and record the result
    // the counter must show after that edge.
    task automatic apply(input bit r, input bit l, input bit m,
                         input int d, input string name);
        exp_t e;
        @(negedge clock);
        reset   = r;
        load    = l;
        mode    = m;
        data_in = count_t'(d);
        if (r)
            model_cnt = 0;
        else if (l)
            model_cnt = (d < COUNT_MAX + 1) ? d : 0;
        else if (m)
            model_cnt = (model_cnt + 1) % (COUNT_MAX + 1);
        else
            model_cnt = (model_cnt + COUNT_MAX) % (COUNT_MAX + 1);
        e.exp  = model_cnt;
        e.name = name;
        exp_q.push_back(e);
        $display("txn %-10s reset=%0b load=%0b mode=%0b data_in=%0d -> expect %0d",
                 name, r, l, m, d, model_cnt);
    endtask

    // Monitor: one expected value is consumed per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (int'(data_out) !== e.exp) begin
                    errors++;
                    $display("FAIL %s: data_out=%0d expected=%0d", e.name, data_out, e.exp);
                end
                checks++;
                if (data_out > count_t'(COUNT_MAX)) begin
                    errors++;
                    $display("FAIL range_%s: data_out=%0d expected<=%0d",
                             e.name, data_out, COUNT_MAX);
                end
            end
        end
    end

    initial begin
        int waited;
        reset   = 1'b1;
        load    = 1'b0;
        mode    = 1'b1;
        data_in = '0;

        // Reset dominates load and mode.
        apply(1, 1, 1, 5, "reset");
        apply(1, 1, 1, 5, "reset_hold");

        // Up count from 0 across the wrap: 1..11,0,1.
        for (int i = 0; i < 13; i++) apply(0, 0, 1, 0, "up_wrap");

        // Load 2 then count down through the wrap: 1,0,11,10.
        apply(0, 1, 1, 2, "load2");
        for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, "down_wrap");

        // Load priority and range coercion.
        apply(0, 1, 0, 7,  "load7");
        apply(0, 1, 1, 13, "load13");
        apply(0, 1, 0, 11, "load11");
        apply(0, 0, 1, 0,  "up_from11");

        // Mid-count reset followed by direction changes.
        apply(1, 0, 1, 0, "rst_mid");
        for (int i = 0; i < 6; i++) apply(0, 0, 1, 0, "up_to6");
        apply(1, 0, 1, 0, "rst_at6");
        apply(0, 0, 0, 0, "down_to11");
        apply(0, 0, 1, 0, "up_to0");

        // Random regression.
        for (int unsigned n = 0; n < no_of_transaction; n++) begin
            bit r, l, m;
            int d;
            r = ($urandom_range(0, 9) == 0);
            l = ($urandom_range(0, 3) == 0);
            m = $urandom_range(0, 1);
            d = $urandom_range(0, 15);
            apply(r, l, m, d, "random");
        end

        // Drain the scoreboard with a bounded wait.
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clock);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mod12_counter
